// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
//   pc_state_t    : sequencer FSM states
//   *_DEFAULT     : default reset and trap vectors
//   is_misaligned : true when an address is not word-aligned
package pc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STALL = 3'd2,
    TRAP  = 3'd3,
    HALT  = 3'd4
  } pc_state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEFAULT  = 32'h0000_0100;

  function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
    return addr_lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-state / next-PC selection for pc_sequencer.
// Ports:
//   state           : current FSM state
//   en, halt_req    : run enable and halt request
//   stall           : hazard stall
//   redirect_valid  : branch/jump redirect this cycle
//   redirect_target : redirect destination
//   pc              : current registered PC
//   next_state      : state to load at the next edge
//   next_pc         : PC to load at the next edge
module pc_next_mux
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEFAULT
) (
  input  pc_state_t       state,
  input  logic            en,
  input  logic            halt_req,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic [XLEN-1:0] pc,
  output pc_state_t       next_state,
  output logic [XLEN-1:0] next_pc
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  always_comb begin
    next_state = state;
    next_pc    = pc;
    case (state)
      IDLE: begin
        // The first fetch after enabling is the reset vector itself.
        next_pc    = RESET_VECTOR;
        next_state = en ? RUN : IDLE;
      end
      RUN, STALL: begin
        if (!en) begin
          next_state = IDLE;
          next_pc    = RESET_VECTOR;
        end else if (halt_req) begin
          next_state = HALT;
        end else if (redirect_valid && is_misaligned(redirect_target[1:0])) begin
          next_state = TRAP;
          next_pc    = TRAP_VECTOR;
        end else if (redirect_valid) begin
          // A redirect flushes, so it wins over a simultaneous stall.
          next_state = RUN;
          next_pc    = redirect_target;
        end else if (stall) begin
          next_state = STALL;
        end else begin
          next_state = RUN;
          // Leaving STALL re-fetches the held PC rather than skipping it.
          next_pc    = (state == RUN) ? pc + PC_STEP : pc;
        end
      end
      TRAP: begin
        if (!en) begin
          next_state = IDLE;
          next_pc    = RESET_VECTOR;
        end else if (halt_req) begin
          next_state = HALT;
        end else begin
          next_state = RUN;
          next_pc    = TRAP_VECTOR;
        end
      end
      HALT: begin
        if (!en) begin
          next_state = IDLE;
          next_pc    = RESET_VECTOR;
        end
      end
      default: begin
        next_state = IDLE;
        next_pc    = RESET_VECTOR;
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the RV32I fetch stage.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   en              : run enable (low forces IDLE at RESET_VECTOR)
//   stall           : hazard stall, hold PC
//   redirect_valid  : taken branch / JAL / JALR
//   redirect_target : redirect destination
//   halt_req        : ECALL/EBREAK retire, stop fetching
//   pc_out          : registered fetch address
//   fetch_valid     : pc_out is a real fetch this cycle
//   trap_pulse      : one-cycle pulse on a misaligned-redirect trap
//   trap_addr       : last faulting redirect target
//   halted          : sequencer is in HALT
//   fetch_count     : wrapping count of fetch_valid cycles
//   state           : current FSM state (debug visibility)
// fetch_valid is a plain qualifier with no back-pressure: the fetch stage
// must consume pc_out in every cycle where fetch_valid is high.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEFAULT,
  parameter int          XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            halt_req,
  output logic [XLEN-1:0] pc_out,
  output logic            fetch_valid,
  output logic            trap_pulse,
  output logic [XLEN-1:0] trap_addr,
  output logic            halted,
  output logic [31:0]     fetch_count,
  output pc_state_t       state
);

  pc_state_t       next_state;
  logic [XLEN-1:0] next_pc;

  pc_next_mux #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RESET_VECTOR),
    .TRAP_VECTOR  (TRAP_VECTOR)
  ) u_next_mux (
    .state           (state),
    .en              (en),
    .halt_req        (halt_req),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc              (pc_out),
    .next_state      (next_state),
    .next_pc         (next_pc)
  );

  // Status outputs are decoded from next_state so they line up with the
  // state register rather than lagging it by a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc_out      <= RESET_VECTOR;
      fetch_valid <= 1'b0;
      trap_pulse  <= 1'b0;
      trap_addr   <= '0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= next_state;
      pc_out      <= next_pc;
      fetch_valid <= (next_state == RUN);
      trap_pulse  <= (next_state == TRAP);
      halted      <= (next_state == HALT);
      if (next_state == TRAP) begin
        trap_addr <= redirect_target;
      end
      if (fetch_valid) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule
